// File: rtl/clutter_frame_scheduler.sv
// Round-robin, frame-granular owner of one shared clutter-removal datapath across NUM_SRC radar point streams.
// One register on ingress and one on egress; a source owns the datapath until its frame has fully drained.
module clutter_frame_scheduler #(
    parameter int NUM_SRC  = 4,
    parameter int PIPE_LAT = 3,
    parameter int W        = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [NUM_SRC-1:0]   src_last,
    input  logic [NUM_SRC*W-1:0] src_point,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic                 dp_valid_in,
    output logic [W-1:0]         dp_point,
    output logic                 dp_clear,
    input  logic                 dp_valid_out,
    input  logic [W-1:0]         dp_clean_point,
    output logic                 out_valid,
    output logic [W-1:0]         out_point,
    output logic [2:0]           out_src_id,
    output logic                 frame_done,
    output logic [2:0]           frame_src_id,
    output logic [15:0]          frame_kept
);
    localparam int CW = $clog2(PIPE_LAT + 3);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d, last_grant_q, last_grant_d, owner_q, owner_d;
    logic          owner_valid_q, owner_valid_d;
    logic [CW-1:0] drain_cnt_q, drain_cnt_d, flush_cnt_q;
    logic [15:0]   kept_q, kept_d;
    logic          seen_q, seen_d;
    logic          frame_done_q, frame_done_d;
    logic          dp_valid_in_q, out_valid_q;
    logic [W-1:0]  dp_point_q, out_point_q;
    logic [2:0]    out_src_id_q;

    logic          arb_found;
    logic [2:0]    arb_idx;
    logic          sel_valid, sel_last, xfer, flush_busy;
    logic [W-1:0]  sel_point;

    // Rotating-priority scan: first requester after the last winner.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (!arb_found && src_valid[k] && k == (int'(last_grant_q) + i) % NUM_SRC) begin
                    arb_found = 1'b1;
                    arb_idx   = 3'(k);
                end
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_point = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_q == 3'(k)) begin
                sel_valid = src_valid[k];
                sel_last  = src_last[k];
                sel_point = src_point[k*W +: W];
            end
        end
    end

    assign xfer       = (state_q == STREAM) && sel_valid;
    assign flush_busy = (flush_cnt_q != '0);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        owner_valid_d = owner_valid_q;
        drain_cnt_d   = drain_cnt_q;
        seen_d        = seen_q;
        kept_d        = kept_q;
        frame_done_d  = 1'b0;
        dp_clear      = 1'b0;
        src_ready     = '0;
        if (out_valid_q && (state_q == STREAM || state_q == DRAIN) && kept_q != 16'hFFFF) begin
            kept_d = kept_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d      = arb_idx;
                    last_grant_d = arb_idx;
                    if (!owner_valid_q || arb_idx != owner_q) begin
                        state_d = CLEAR;
                    end else begin
                        // Same owner again: the background model keeps its history.
                        state_d = STREAM;
                        kept_d  = '0;
                        seen_d  = 1'b0;
                    end
                end
            end
            CLEAR: begin
                dp_clear      = 1'b1;
                owner_d       = grant_q;
                owner_valid_d = 1'b1;
                state_d       = STREAM;
                kept_d        = '0;
                seen_d        = 1'b0;
            end
            STREAM: begin
                for (int k = 0; k < NUM_SRC; k++) begin
                    src_ready[k] = (grant_q == 3'(k));
                end
                if (xfer) begin
                    seen_d = 1'b1;
                    if (sel_last) begin
                        state_d     = DRAIN;
                        drain_cnt_d = '0;
                    end
                end
            end
            DRAIN: begin
                // Covers the ingress register, the datapath and the egress register.
                if (drain_cnt_q == CW'(PIPE_LAT + 1)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            last_grant_q  <= 3'(NUM_SRC - 1);
            owner_q       <= '0;
            owner_valid_q <= 1'b0;
            drain_cnt_q   <= '0;
            flush_cnt_q   <= CW'(PIPE_LAT + 1);
            kept_q        <= '0;
            seen_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            dp_valid_in_q <= 1'b0;
            dp_point_q    <= '0;
            out_valid_q   <= 1'b0;
            out_point_q   <= '0;
            out_src_id_q  <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            owner_valid_q <= owner_valid_d;
            drain_cnt_q   <= drain_cnt_d;
            kept_q        <= kept_d;
            seen_q        <= seen_d;
            frame_done_q  <= frame_done_d;
            dp_valid_in_q <= xfer;
            if (xfer) begin
                dp_point_q <= sel_point;
            end
            // Results still in the datapath from before a reset are dropped.
            if (flush_busy) begin
                flush_cnt_q <= flush_cnt_q - CW'(1);
            end
            out_valid_q  <= dp_valid_out && !flush_busy;
            out_point_q  <= dp_clean_point;
            out_src_id_q <= owner_q;
        end
    end

    assign dp_valid_in  = dp_valid_in_q;
    assign dp_point     = dp_point_q;
    assign out_valid    = out_valid_q;
    assign out_point    = out_point_q;
    assign out_src_id   = out_src_id_q;
    assign frame_done   = frame_done_q;
    assign frame_src_id = frame_done_q ? owner_q : 3'd0;
    assign frame_kept   = frame_done_q ? kept_q : 16'd0;

    a_no_stray_dp_out: assert property (@(posedge clk) disable iff (reset)
        (dp_valid_out && !flush_busy) |-> ((state_q == STREAM && seen_q) || state_q == DRAIN));

endmodule
